// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the sequential shift unit
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one fixed-distance shift step, combinational
module shift_stage
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int DIST = 1
) (
    input  logic [N-1:0] data,
    input  shift_op_t    op,
    input  logic         sign,
    input  logic         en,
    output logic [N-1:0] result
);

    // Shift by DIST when enabled; sign is the original operand MSB so SRA fills correctly
    always_comb begin
        result = data;
        if (en) begin
            case (op)
                SLL:     result = {data[N-1-DIST:0], {DIST{1'b0}}};
                SRL:     result = {{DIST{1'b0}}, data[N-1:DIST]};
                SRA:     result = {{DIST{sign}}, data[N-1:DIST]};
                ROL:     result = {data[N-1-DIST:0], data[N-1:N-DIST]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - barrel shift done one power-of-two step per cycle
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int  N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] shamt,
    input  shift_op_t    op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero
);

    state_t        state;
    state_t        state_next;
    logic [L-1:0]  k;
    logic [N-1:0]  work;
    logic [L-1:0]  shamt_r;
    shift_op_t     op_r;
    logic          sign_r;
    logic [N-1:0]  stage_res [L];
    logic [N-1:0]  step_res;
    logic          last_step;

    // One stage per bit of shamt; stage i moves the word by 2^i when shamt[i] is set
    for (genvar i = 0; i < L; i++) begin : g_stage
        shift_stage #(
            .N    (N),
            .DIST (1 << i)
        ) u_stage (
            .data   (work),
            .op     (op_r),
            .sign   (sign_r),
            .en     (shamt_r[i]),
            .result (stage_res[i])
        );
    end

    // Pick the stage matching the current step counter
    always_comb begin
        step_res = work;
        for (int i = 0; i < L; i++) begin
            if (k == L'(i)) step_res = stage_res[i];
        end
    end

    assign last_step = (k == L'(L - 1));

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand capture, per-cycle stepping, and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            work     <= '0;
            shamt_r  <= '0;
            op_r     <= SLL;
            sign_r   <= 1'b0;
            out_data <= '0;
            out_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= in_data;
                        shamt_r <= shamt;
                        op_r    <= op;
                        sign_r  <= in_data[N-1];
                        k       <= '0;
                    end
                end
                BUSY: begin
                    work <= step_res;
                    k    <= k + 1'b1;
                    if (last_step) begin
                        out_data <= step_res;
                        out_zero <= (step_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - scoreboard bench for shift_unit_seq
module tb_shift_unit_seq;
    import shift_pkg::*;

    localparam int N = 32;
    localparam int L = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic [L-1:0] shamt = '0;
    shift_op_t    op = SLL;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q [$];

    shift_unit_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int s, input int o);
        logic [2*N-1:0] dbl;
        case (o)
            0: return x << s;
            1: return x >> s;
            2: return N'($signed(x) >>> s);
            default: begin
                dbl = {x, x} << s;
                return dbl[2*N-1:N];
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        in_valid = 1'b1;
        in_data  = $urandom;
        shamt    = L'($urandom_range(0, N - 1));
        op       = shift_op_t'($urandom_range(0, 3));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", N'(in_ready), N'(1));
    endtask

    task automatic run_req(input logic [N-1:0] d, input int s, input int o, input int hold);
        logic [N-1:0] held;
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        shamt    = L'(s);
        op       = shift_op_t'(o);
        exp_q.push_back(ref_shift(d, s, o));
        tick();
        chk("busy_not_ready", N'(in_ready), N'(0));
        for (int i = 1; i <= L; i++) begin
            junk_inputs();
            tick();
            chk("latency_valid", N'(out_valid), N'(i == L));
        end
        held = out_data;
        for (int j = 0; j < hold; j++) begin
            junk_inputs();
            tick();
            chk("hold_valid", N'(out_valid), N'(1));
            chk("hold_not_ready", N'(in_ready), N'(0));
            chk("hold_stable", out_data, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_idle", N'(in_ready), N'(1));
        chk("handoff_no_valid", N'(out_valid), N'(0));
        chk("idle_retains", out_data, held);
    endtask

    // Monitor: compare every result the DUT hands off against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", out_data);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                chk("result_data", out_data, e);
                chk("result_zero", N'(out_zero), N'(e == '0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_out_valid", N'(out_valid), N'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_zero", N'(out_zero), N'(1));
        rst = 1'b0;
        chk("rst_in_ready", N'(in_ready), N'(1));

        run_req(32'h0000_0001, 31, 0, 0);
        run_req(32'h8000_0000, 4, 2, 1);
        run_req(32'h8000_0000, 4, 1, 0);
        run_req(32'h8000_0001, 1, 3, 0);
        run_req(32'h0000_0000, 7, 0, 0);
        for (int o = 0; o < 4; o++) run_req(32'hDEAD_BEEF, 0, o, 0);
        run_req(32'h1234_5678, 13, 3, 3);

        // Reset in the middle of BUSY discards the operation
        wait_ready();
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        shamt    = 5'd3;
        op       = SRL;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", N'(out_valid), N'(0));
        chk("midrst_data", out_data, '0);
        chk("midrst_zero", N'(out_zero), N'(1));
        chk("midrst_ready", N'(in_ready), N'(1));
        for (int i = 0; i < L + 2; i++) begin
            tick();
            chk("midrst_no_result", N'(out_valid), N'(0));
        end
        run_req(32'hCAFE_F00D, 9, 2, 0);

        for (int t = 0; t < 40; t++) begin
            run_req($urandom, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)));
        end

        tick();
        tick();
        chk("sb_empty", N'(exp_q.size()), N'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
